// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word fall-through byte FIFO and sticky error flags.
// Line timing is measured on the synchronized line; every bit is sampled mid-period.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 10_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clear_errors
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam int PW               = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] SYM_END    = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_END = CW'(SAMPLE_TIME - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          sync1;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic stop_edge;
  logic push_req;
  logic frame_set;
  logic full;
  logic pop;
  logic do_push;
  logic ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
    end
  end

  // cnt is cleared on every state entry, including each DATA bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == SAMPLE_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == SYM_END) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == SYM_END) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign stop_edge = (state == S_STOP) && (cnt == SYM_END);
  assign push_req  = stop_edge && rx_s;
  assign frame_set = stop_edge && !rx_s;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign full    = (fifo_count == FULL_COUNT);
  assign pop     = data_out_valid && data_out_ready;
  assign do_push = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Setting an error wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~clear_errors);
      overflow  <= ovf_set   | (overflow  & ~clear_errors);
    end
  end

  assign data_out_valid = (fifo_count != '0);
  assign data_out       = data_out_valid ? mem[rptr] : 8'h00;
  assign rx_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven at 8680 ns/bit against a 100 ns clock,
// with cycle-exact checks around the stop sample (edge 820 after a start bit driven just past an edge).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam time BIT_NS = 8680;

  logic       clk;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [3:0] fifo_count;
  logic       rx_busy;
  logic       frame_err;
  logic       overflow;
  logic       clear_errors;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] popped;

  uart_rx_fifo dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .rx_busy        (rx_busy),
    .frame_err      (frame_err),
    .overflow       (overflow),
    .clear_errors   (clear_errors)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #6ms;
    $display("FAIL watchdog: run did not reach the summary (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks; send_frame leaves the line at the stop-bit level
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    serial_in = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      #BIT_NS;
    end
    serial_in = stop_bit;
    #BIT_NS;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(posedge clk);
    #1;
    send_frame(d, 1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic fill(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(first + 8'(i));
      exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    @(negedge clk);
    data_out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(data_out_valid), 32'd1);
      check({tag, "_data"}, 32'(data_out), 32'(e));
      @(negedge clk);
    end
    data_out_ready = 1'b0;
    check({tag, "_empty"}, 32'(fifo_count), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    clear_errors = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_flags", 32'({frame_err, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // single byte with ready held high: visible one cycle after stop sample, popped next
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_frame(8'h61, 1'b1);
      begin
        repeat (819) @(posedge clk);
        @(negedge clk);
        check("t1_before_valid", 32'(data_out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t1_valid", 32'(data_out_valid), 32'd1);
        check("t1_data", 32'(data_out), 32'h61);
        check("t1_count1", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("t1_count0", 32'(fifo_count), 32'd0);
        check("t1_valid0", 32'(data_out_valid), 32'd0);
      end
    join
    data_out_ready = 1'b0;
    check("t1_flags", 32'({frame_err, overflow}), 32'd0);
    repeat (20) @(posedge clk);

    // fill to full, overflow on the ninth byte, drain in order
    fill(8'h61, 8);
    check("t2_full", 32'(fifo_count), 32'd8);
    check("t2_no_ovf", 32'(overflow), 32'd0);
    send_byte(8'h69);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_count", 32'(fifo_count), 32'd8);
    drain("t2");
    check("t2_ovf_sticky", 32'(overflow), 32'd1);
    pulse_clear();
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // framing error, line held low, then recovery
    @(posedge clk);
    #1;
    send_frame(8'h55, 1'b0);
    check("t3_ferr", 32'(frame_err), 32'd1);
    check("t3_count", 32'(fifo_count), 32'd0);
    check("t3_busy", 32'(rx_busy), 32'd1);
    #(20 * BIT_NS);
    check("t3_break_busy", 32'(rx_busy), 32'd1);
    check("t3_break_count", 32'(fifo_count), 32'd0);
    serial_in = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3_idle", 32'(rx_busy), 32'd0);
    pulse_clear();
    check("t3_ferr_clr", 32'(frame_err), 32'd0);
    send_byte(8'h3C);
    exp_q.push_back(8'h3C);
    drain("t3");

    // short low glitch is rejected
    @(posedge clk);
    #1;
    serial_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    serial_in = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_busy", 32'(rx_busy), 32'd1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t4_idle", 32'(rx_busy), 32'd0);
    check("t4_count", 32'(fifo_count), 32'd0);
    check("t4_flags", 32'({frame_err, overflow}), 32'd0);

    // push and pop on the exact stop-sample cycle while full
    fill(8'h61, 8);
    @(posedge clk);
    #1;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (819) @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        popped = exp_q.pop_front();
        check("t5_head", 32'(data_out), 32'(popped));
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        exp_q.push_back(8'h7E);
      end
    join
    check("t5_no_ovf", 32'(overflow), 32'd0);
    check("t5_count", 32'(fifo_count), 32'd8);
    drain("t5");

    // reset during a frame with bytes queued
    fill(8'h11, 3);
    check("t6_pre_count", 32'(fifo_count), 32'd3);
    @(posedge clk);
    #1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (400) @(posedge clk);
        #1;
        check("t6_pre_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_valid", 32'(data_out_valid), 32'd0);
        check("t6_rst_data", 32'(data_out), 32'd0);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        check("t6_rst_flags", 32'({frame_err, overflow}), 32'd0);
      end
    join
    exp_q.delete();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(8'h5A);
    @(negedge clk);
    check("t6_count", 32'(fifo_count), 32'd1);
    check("t6_data", 32'(data_out), 32'h5A);
    exp_q.push_back(8'h5A);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- On-chip UART receiver for the hdp_rv151 SoC; receive end of the host serial link (8N1, LSB first).
- Host drives serial_in; block detects start bit, samples each bit at mid-period, checks stop bit.
- Good bytes go into a small FIFO read by the CPU MMIO path through a ready/valid dequeue port.
- Framing errors and overflow are reported as sticky flags.

Parameters:
- CLOCK_FREQ, 10_000_000: core clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- FIFO_DEPTH, 8: byte entries; power of two, at least 2.
- Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, which is 86 at the defaults. SAMPLE_TIME = SYMBOL_EDGE_TIME/2, which is 43.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- serial_in  in  1  UART line; idles high; asynchronous to clk.
- data_out  out  8  byte at the FIFO head.
- data_out_valid  out  1  FIFO not empty.
- data_out_ready  in  1  consumer accepts data_out.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
- rx_busy  out  1  a frame is being received (state is not IDLE).
- frame_err  out  1  sticky: a stop bit was sampled 0.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- clear_errors  in  1  one-cycle pulse that clears frame_err and overflow.

Behaviour:
- Reset (already decided): one clock, clk. rst_n is asynchronous and active-low.
- Reset values: data_out=0, data_out_valid=0, fifo_count=0, rx_busy=0, frame_err=0, overflow=0. FIFO pointers = 0. FSM = IDLE. Both synchronizer flops = 1.
- serial_in passes through a 2-flop synchronizer. The internal line is rx_s. All line timing is referenced to rx_s.
- Bit counter: counts clk cycles 0..SYMBOL_EDGE_TIME-1 and resets on every state entry.
- FSM states:
  - IDLE: rx_s==0 -> START.
  - START: at count==SAMPLE_TIME-1, if rx_s==0 -> DATA (bit index 0), otherwise IDLE. A low glitch shorter than half a bit is rejected.
  - DATA: at count==SYMBOL_EDGE_TIME-1, shift rx_s into shift[7] (shift right, so the byte comes out LSB first). After the 8th bit -> STOP.
  - STOP: at count==SYMBOL_EDGE_TIME-1, sample rx_s.
    - Sample 1: push the byte to the FIFO; if the FIFO is full, drop the byte and set overflow. Go to IDLE.
    - Sample 0: set frame_err, drop the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A line held low never produces bytes.
- Every sample falls mid-bit: 1.5 bit-times after the start edge for bit 0, plus the 2-cycle synchronizer lag.
- FIFO:
  - First-word fall-through. data_out shows the head whenever data_out_valid=1.
  - Pop occurs when data_out_valid && data_out_ready.
  - A push becomes visible on data_out_valid/fifo_count the cycle after the stop sample.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Simultaneous events:
  - Push and pop in the same cycle while not empty: both happen, fifo_count unchanged.
  - Push and pop in the same cycle while full: the pop frees the slot, the push succeeds, overflow is not set.
  - Push while empty with ready=1: the byte appears next cycle; it is not bypassed the same cycle.
  - clear_errors in the same cycle as a new error: the set wins and the flag stays 1.
- data_out_ready while empty is ignored. The pointer does not move.
- Reset mid-frame: the FSM aborts to IDLE and FIFO contents are discarded. A frame begun after reset release with the line idle is received normally.

Test Plan:
- Idle, then send 0x61 at 8680 ns/bit with data_out_ready=1 -> one cycle after the stop sample, data_out=0x61 and data_out_valid=1; popped next cycle; fifo_count goes 1 then 0; flags stay 0.
- data_out_ready=0; send 0x61..0x68 -> fifo_count=8. Send 0x69 -> overflow=1, count stays 8. Then ready=1 -> pops 0x61..0x68 in order. clear_errors -> overflow=0.
- Send 0x55 with stop bit 0 -> frame_err=1, count unchanged. Hold the line low 20 bit-times -> no push, rx_busy stays 1. Release, send 0x3C -> 0x3C received.
- 20-cycle low pulse on an idle line -> back to IDLE, rx_busy drops, no push.
- FIFO full with ready=1 asserted on the exact cycle of the stop sample of 0x7E -> overflow=0, fifo_count stays 8, 0x7E is the last byte popped.
- Assert rst_n=0 after the 4th data bit of 0xA5 with 3 bytes queued -> all outputs at reset values immediately. Release, send 0x5A -> data_out=0x5A, fifo_count=1.
